// File: rtl/bow_draw_ctrl.sv
// Bow draw/fire controller feeding bow_color: turns button, frame tick and game-active
// into the 4-bit bow_state, a one-cycle fire pulse with power, and the ammo count.
module bow_draw_ctrl #(
  parameter int FRAMES_PER_STAGE = 6,
  parameter int MIN_FIRE_STAGE   = 2,
  parameter int COOLDOWN_FRAMES  = 10,
  parameter int AMMO_MAX         = 16,
  parameter int AMMO_W           = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_frame_tick,
  input  logic              i_game_active,
  input  logic              i_draw_btn,
  input  logic              i_refill,
  output logic [3:0]        o_bow_state,
  output logic              o_arrow_fire,
  output logic [2:0]        o_arrow_power,
  output logic [AMMO_W-1:0] o_arrows_left
);

  localparam int CNT_MAX = (FRAMES_PER_STAGE > COOLDOWN_FRAMES) ? FRAMES_PER_STAGE
                                                                 : COOLDOWN_FRAMES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  STAGE_TICKS = CNT_W'(FRAMES_PER_STAGE);
  localparam logic [CNT_W-1:0]  COOL_TICKS  = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [2:0]        FIRE_STAGE  = 3'(MIN_FIRE_STAGE);
  localparam logic [AMMO_W-1:0] AMMO_FULL   = AMMO_W'(AMMO_MAX);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_IDLE = 2'd1,
    S_DRAW = 2'd2,
    S_COOL = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_stage;
  logic [2:0]        w_stage_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              r_btn_prev;
  logic              w_press;
  logic              w_fire;
  logic [3:0]        r_bow_state;
  logic [3:0]        w_bow_next;
  logic              r_arrow_fire;
  logic [2:0]        r_arrow_power;
  logic [AMMO_W-1:0] r_arrows_left;

  assign w_press   = i_draw_btn & ~r_btn_prev;
  assign w_cnt_inc = r_cnt + 1'b1;

  // One frame counter is shared: it times draw stages in DRAW and the flash in COOL.
  always_comb begin
    w_state_next = r_state;
    w_stage_next = r_stage;
    w_cnt_next   = r_cnt;
    w_fire       = 1'b0;
    if (!i_game_active) begin
      w_state_next = S_OFF;
      w_stage_next = 3'd0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_next = S_IDLE;
        end
        S_IDLE: begin
          if (w_press && (r_arrows_left != '0)) begin
            w_state_next = S_DRAW;
            w_stage_next = 3'd1;
            w_cnt_next   = '0;
          end
        end
        S_DRAW: begin
          if (!i_draw_btn) begin
            w_cnt_next   = '0;
            w_stage_next = 3'd0;
            if (r_stage >= FIRE_STAGE) begin
              w_state_next = S_COOL;
              w_fire       = 1'b1;
            end else begin
              w_state_next = S_IDLE;
            end
          end else if (i_frame_tick) begin
            if (w_cnt_inc == STAGE_TICKS) begin
              w_cnt_next = '0;
              if (r_stage != 3'd5) begin
                w_stage_next = r_stage + 3'd1;
              end
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        end
        S_COOL: begin
          if (i_frame_tick) begin
            if (w_cnt_inc == COOL_TICKS) begin
              w_state_next = S_IDLE;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        end
        default: begin
          w_state_next = S_OFF;
        end
      endcase
    end
  end

  always_comb begin
    w_bow_next = 4'd0;
    case (w_state_next)
      S_OFF:   w_bow_next = 4'd0;
      S_IDLE:  w_bow_next = 4'd7;
      S_DRAW:  w_bow_next = {1'b0, w_stage_next};
      S_COOL:  w_bow_next = 4'd6;
      default: w_bow_next = 4'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_OFF;
      r_stage       <= 3'd0;
      r_cnt         <= '0;
      r_btn_prev    <= 1'b0;
      r_bow_state   <= 4'd0;
      r_arrow_fire  <= 1'b0;
      r_arrow_power <= 3'd0;
      r_arrows_left <= AMMO_FULL;
    end else begin
      r_state      <= w_state_next;
      r_stage      <= w_stage_next;
      r_cnt        <= w_cnt_next;
      r_btn_prev   <= i_draw_btn;
      r_bow_state  <= w_bow_next;
      r_arrow_fire <= w_fire;
      if (w_fire) begin
        r_arrow_power <= r_stage;
      end
      // Refill takes priority over a same-cycle shot.
      if (i_refill) begin
        r_arrows_left <= AMMO_FULL;
      end else if (w_fire && (r_arrows_left != '0)) begin
        r_arrows_left <= r_arrows_left - 1'b1;
      end
    end
  end

  assign o_bow_state   = r_bow_state;
  assign o_arrow_fire  = r_arrow_fire;
  assign o_arrow_power = r_arrow_power;
  assign o_arrows_left = r_arrows_left;

endmodule
